// File: rtl/match_controller_pkg.sv
// match_controller_pkg: shared FSM state, winner and player encodings for the match controller.
package match_controller_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, PLAY, SCORE, OVER} state_t;
  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_X = 2'b01;
  localparam logic [1:0] WINNER_O = 2'b10;
  localparam logic PLAYER_X = 1'b0;
  localparam logic PLAYER_O = 1'b1;
endpackage

// File: rtl/match_controller_move_timer.sv
// move_timer: per-move cycle counter, exists only when MATCH_TIMEOUT_EN is defined.
`ifdef MATCH_TIMEOUT_EN
module move_timer #(
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] count;
  assign expired = count == W'(TIMEOUT_CYCLES);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (load) count <= '0;
    else if (enable && !expired) count <= count + W'(1);
  end
endmodule
`endif

// File: rtl/match_controller.sv
// match_controller: tic-tac-toe match sequencer (clear, turns, round scoring, match end).
// Optional per-move forfeit timer enabled by defining MATCH_TIMEOUT_EN.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int TARGET_WINS = 5,
  parameter int ROUND_W = 6,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               move_done,
  input  logic               win_x,
  input  logic               win_o,
  input  logic               draw,
  input  logic               board_cleared,
  output logic               clear_board,
  output logic               clear_scores,
  output logic               incrementX,
  output logic               incrementO,
  output logic               turn,
  output logic               first_player,
  output logic [ROUND_W-1:0] round_count,
  output logic               match_over,
  output logic [1:0]         winner
);
  state_t state;
  logic [5:0] mirror_x, mirror_o;
  logic expired, idle_in, x_wins, o_wins, result;
`ifdef MATCH_TIMEOUT_EN
  move_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(state != PLAY || move_done),
    .enable(state == PLAY),
    .expired(expired)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif
  // A timeout forfeits to the player not on turn, but any real result input wins over it.
  assign idle_in = !win_x && !win_o && !draw;
  assign x_wins = (win_x && !win_o) || (idle_in && expired && turn == PLAYER_O);
  assign o_wins = (win_o && !win_x) || (idle_in && expired && turn == PLAYER_X);
  assign result = win_x || win_o || draw || expired;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mirror_x <= '0;
      mirror_o <= '0;
      round_count <= '0;
      clear_board <= 1'b0;
      clear_scores <= 1'b0;
      incrementX <= 1'b0;
      incrementO <= 1'b0;
      turn <= PLAYER_X;
      first_player <= PLAYER_X;
      match_over <= 1'b0;
      winner <= WINNER_NONE;
    end else begin
      clear_scores <= 1'b0;
      incrementX <= 1'b0;
      incrementO <= 1'b0;
      case (state)
        IDLE, OVER: if (start) begin
          state <= CLEAR;
          clear_scores <= 1'b1;
          clear_board <= 1'b1;
          mirror_x <= '0;
          mirror_o <= '0;
          round_count <= '0;
          first_player <= PLAYER_X;
          match_over <= 1'b0;
          winner <= WINNER_NONE;
        end
        CLEAR: if (board_cleared) begin
          state <= PLAY;
          clear_board <= 1'b0;
          turn <= first_player;
        end
        PLAY: if (result) begin
          state <= SCORE;
          incrementX <= x_wins;
          incrementO <= o_wins;
          mirror_x <= mirror_x + 6'(x_wins);
          mirror_o <= mirror_o + 6'(o_wins);
          round_count <= round_count + ROUND_W'(round_count != '1);
        end else if (move_done) turn <= ~turn;
        SCORE: if (mirror_x == 6'(TARGET_WINS) || mirror_o == 6'(TARGET_WINS)) begin
          state <= OVER;
          match_over <= 1'b1;
          winner <= mirror_x == 6'(TARGET_WINS) ? WINNER_X : WINNER_O;
        end else begin
          state <= CLEAR;
          clear_board <= 1'b1;
          first_player <= ~first_player;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: scoreboard bench for match_controller with TARGET_WINS=2.
module tb_match_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic start = 1'b0, move_done = 1'b0, win_x = 1'b0, win_o = 1'b0, draw = 1'b0, board_cleared = 1'b0;
  logic clear_board, clear_scores, incrementX, incrementO, turn, first_player, match_over;
  logic [5:0] round_count;
  logic [1:0] winner;
  int checks = 0, errors = 0;
  logic [1:0] sb[$];

  match_controller #(.TARGET_WINS(2), .ROUND_W(6), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .start(start), .move_done(move_done), .win_x(win_x), .win_o(win_o),
    .draw(draw), .board_cleared(board_cleared), .clear_board(clear_board), .clear_scores(clear_scores),
    .incrementX(incrementX), .incrementO(incrementO), .turn(turn), .first_player(first_player),
    .round_count(round_count), .match_over(match_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one-cycle pulse on {start, move_done, win_x, win_o, draw}
  task automatic apply(input logic [4:0] v);
    {start, move_done, win_x, win_o, draw} = v;
    step();
    {start, move_done, win_x, win_o, draw} = '0;
  endtask

  task automatic clear_done();
    board_cleared = 1'b1;
    step();
    board_cleared = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_outs"}, {clear_board, clear_scores, incrementX, incrementO, turn, first_player, match_over}, 0);
    check({tag, "_round"}, round_count, 0);
    check({tag, "_winner"}, winner, 0);
  endtask

  always @(negedge clk)
    if (incrementX || incrementO) begin
      if (sb.size() == 0) check("unexpected_inc", {incrementX, incrementO}, 0);
      else check("inc", {incrementX, incrementO}, sb.pop_front());
    end

  initial begin
    repeat (2) step();
    check_idle("reset");
    reset = 1'b0;
    step();
    check_idle("idle");
    apply(5'b10000);
    check("new_clear_scores", clear_scores, 1);
    check("new_clear_board", clear_board, 1);
    clear_done();
    check("play_clear_scores", clear_scores, 0);
    check("play_clear_board", clear_board, 0);
    check("play_turn", turn, 0);
    repeat (3) apply(5'b01000);
    check("three_moves_turn", turn, 1);
    apply(5'b01110);
    check("both_turn_held", turn, 1);
    check("both_no_inc", {incrementX, incrementO}, 0);
    check("both_round", round_count, 1);
    step();
    check("both_first_player", first_player, 1);
    check("both_clear_board", clear_board, 1);
    clear_done();
    check("r2_turn", turn, 1);
    apply(5'b10000);
    check("start_in_play_scores", clear_scores, 0);
    check("start_in_play_round", round_count, 1);
    sb.push_back(2'b10);
    apply(5'b00100);
    check("r2_incx_latency", incrementX, 1);
    step();
    check("r2_first_player", first_player, 0);
    check("r2_not_over", match_over, 0);
    clear_done();
    sb.push_back(2'b01);
    apply(5'b01010);
    check("r3_inco_latency", incrementO, 1);
    check("r3_round", round_count, 3);
    step();
    clear_done();
    sb.push_back(2'b10);
    apply(5'b00100);
    step();
    check("over_flag", match_over, 1);
    check("over_winner", winner, 2'b01);
    check("over_round", round_count, 4);
    apply(5'b00010);
    apply(5'b01000);
    check("over_ignores_winner", winner, 2'b01);
    apply(5'b10000);
    check("restart_clear_scores", clear_scores, 1);
    check("restart_round", round_count, 0);
    check("restart_clear_board", clear_board, 1);
    check("restart_match_over", match_over, 0);
    check("restart_winner", winner, 0);
    step();
    check("restart_scores_pulse", clear_scores, 0);
    clear_done();
    apply(5'b01000);
    win_x = 1'b1;
    #2 reset = 1'b1;
    step();
    win_x = 1'b0;
    check_idle("mid_play_reset");
    reset = 1'b0;
    repeat (2) step();
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
